memblk_pq: RTL and testbench
============================

Name: memblk_pq

Overview:
- Parametrised successor of the shared memory block: NPORT read and NPORT write ports into one DEPTH-word array.
- A request pipeline of LAT stages feeds a single access stage (stage LAT-1).
- Writes are posted into an HZW-deep write buffer and commit to the array later.
- Each word carries a metadata field {xdata, shared}. Reads that hit a posted write stall the pipeline, or forward under the optional feature.

Parameters:
NPORT, 4, number of read ports and number of write ports
AW, 16, address width; DEPTH = 1<<AW words
DW, 64, data width per word
XW, 4, metadata xdata width
LAT, 4, request pipeline stages (>=2); access stage index A=LAT-1
HZW, 4, posted-write buffer depth (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
stall  out  1  upstream must hold all request inputs while high
noshare  in  1  when high, reads at A clear shared bit instead of setting it
rd_en  in  NPORT  read request valid per port
rd_addr  in  NPORT*AW  read addresses
rd_xdata  in  NPORT*XW  xdata written into metadata by the read
rd_valid  out  NPORT  read response valid
rd_data  out  NPORT*DW  read response data
rd_meta  out  NPORT*(XW+1)  pre-update metadata {xdata, shared}
wr_en  in  NPORT  write request valid per port
wr_addr  in  NPORT*AW  write addresses
wr_data  in  NPORT*DW  write data

Behaviour:
- Reset (rst=0, async):
  - Clears all pipeline valids, write-buffer valids, rd_valid, rd_data, rd_meta and the metadata array.
  - stall=0. The data array is not reset.
- Capture: when stall=0, inputs enter stage 0 and stages 0..A advance every clk.
- stall (combinational): high when any valid read at A has an address equal to any valid write-buffer entry.
- During stall:
  - Stages 0..A freeze; stage-0 capture is suppressed.
  - The write buffer keeps shifting and a bubble is inserted at entry 0.
  - rd_valid=0 that cycle.
- Latency: a read accepted at cycle t yields rd_valid at t+LAT+1, plus one cycle per stall cycle.
- Access stage A (stall=0):
  - Reads take data from the array and take metadata pre-update. Both are registered to the outputs one cycle later.
  - Writes at A enter write-buffer entry 0.
  - A read and a write to the same address at A in the same cycle: the read returns the old value.
- Write buffer:
  - Entry k holds the writes that were at A k+1 cycles earlier.
  - At each clk edge, entry HZW-1 commits to the array and clears that word's shared bit.
  - A write at A in cycle T is visible in the array from T+HZW+1.
- Metadata update on a read at A: xdata<=rd_xdata; shared<=~noshare.
- Same-address collisions in one cycle:
  - Multiple reads: the highest port index wins the metadata update.
  - Multiple writes: the highest port index wins at commit.
- Stall bound: a maximum of HZW consecutive cycles per hazard; no deadlock possible.
- Reset mid-operation: in-flight reads are dropped (no rd_valid) and uncommitted posted writes are discarded.

Optional Feature:
MEMBLK_PQ_FWD_EN
- Defined:
  - A read at A that hits the write buffer takes data from the youngest matching entry (lowest k; highest port within that entry).
  - stall is tied 0.
  - Metadata is still read from the array.
- Undefined: stall behaviour as above.

Decomposition:
- Package memblk_pq_pkg holds:
  - meta_t struct {xdata[XW-1:0], shared}
  - rd_req_t {en, addr, xdata}
  - wr_req_t {en, addr, data}
  - localparam A=LAT-1
- Sub-module memblk_pq_wbuf:
  - HZW x NPORT shift buffer of wr_req_t with per-port address-match outputs.
  - Youngest-hit data mux, used under FWD_EN.
  - Commit port.

Test Plan:
- Reset: drive rst=0 during traffic -> rd_valid=0, stall=0 next edge; post-reset read of 0x0042 returns meta {0x0,0}.
- Write, then read after commit: port0 writes 0x0010=0xDEADBEEF at t0; port1 reads 0x0010 at t0+8 -> rd_valid at t0+13 with 0xDEADBEEF, stall never high.
- Write, then read back-to-back: write 0x0010 at t0, read 0x0010 at t0+1 -> stall high exactly 4 cycles, data 0xDEADBEEF at t0+10.
  - With MEMBLK_PQ_FWD_EN: no stall, data at t0+6.
- Same-cycle write collision: ports 1 and 3 write 0x0020 = 0x1111 and 0x3333 -> later read returns 0x3333.
- Metadata: read 0x0030 with xdata=0xA, noshare=0 -> next read's rd_meta={0xA,1}.
  - Then write 0x0030 and wait for commit -> read meta={0xA,0}.
  - Read with noshare=1 -> shared cleared.
- Upstream hold: during a forced 4-cycle stall, change inputs only after stall drops -> no request lost or duplicated; 8 reads in yield 8 rd_valid pulses.

Source files
------------

// File: rtl/memblk_pq_pkg.sv
// memblk_pq_pkg: shared types and sizing for the memblk_pq multi-port memory.
//   PQ_*   default sizes. Struct field widths follow these, so the module
//          parameters of memblk_pq must match them.
//   A      index of the access stage (PQ_LAT-1)
//   meta_t per-word metadata {xdata, shared}
//   rd_req_t / wr_req_t  per-port request slots carried down the pipeline
package memblk_pq_pkg;
    localparam int PQ_NPORT = 4;
    localparam int PQ_AW    = 16;
    localparam int PQ_DW    = 64;
    localparam int PQ_XW    = 4;
    localparam int PQ_LAT   = 4;
    localparam int PQ_HZW   = 4;
    localparam int A        = PQ_LAT - 1;

    typedef struct packed {
        logic [PQ_XW-1:0] xdata;
        logic             shared;
    } meta_t;

    typedef struct packed {
        logic             en;
        logic [PQ_AW-1:0] addr;
        logic [PQ_XW-1:0] xdata;
    } rd_req_t;

    typedef struct packed {
        logic             en;
        logic [PQ_AW-1:0] addr;
        logic [PQ_DW-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/memblk_pq_wbuf.sv
// memblk_pq_wbuf: HZW-deep posted-write buffer, NPORT writes per entry.
// Entry 0 takes the writes leaving the access stage (or a bubble when
// push_i=0); the last entry is presented on cmt_o for commit every cycle.
//   clk, rst     clock, async active-low reset (clears all entries)
//   push_i       1: load wr_i into entry 0, 0: insert a bubble
//   wr_i         writes from the access stage
//   rd_addr_i    access-stage read addresses to match against
//   hit_o        per read port: some valid entry holds that address
//   cmt_o        oldest entry, committing this edge
//   fwd_data_o   (MEMBLK_PQ_FWD_EN only) youngest matching write data
module memblk_pq_wbuf
    import memblk_pq_pkg::*;
#(
    parameter int NPORT = PQ_NPORT,
    parameter int HZW   = PQ_HZW
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push_i,
    input  wr_req_t [NPORT-1:0]             wr_i,
    input  logic    [NPORT-1:0][PQ_AW-1:0]  rd_addr_i,
    output logic    [NPORT-1:0]             hit_o,
    output wr_req_t [NPORT-1:0]             cmt_o
`ifdef MEMBLK_PQ_FWD_EN
    ,
    output logic    [NPORT-1:0][PQ_DW-1:0]  fwd_data_o
`endif
);
    wr_req_t [NPORT-1:0] ent_q [HZW];

    // The buffer never holds: it shifts every cycle, which is what bounds
    // any hazard stall to HZW cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < HZW; k++) ent_q[k] <= '0;
        end else begin
            ent_q[0] <= push_i ? wr_i : '0;
            for (int k = 1; k < HZW; k++) ent_q[k] <= ent_q[k-1];
        end
    end

    assign cmt_o = ent_q[HZW-1];

    always_comb begin
        hit_o = '0;
        for (int p = 0; p < NPORT; p++)
            for (int k = 0; k < HZW; k++)
                for (int q = 0; q < NPORT; q++)
                    if (ent_q[k][q].en && ent_q[k][q].addr == rd_addr_i[p]) hit_o[p] = 1'b1;
    end

`ifdef MEMBLK_PQ_FWD_EN
    // Walk oldest to youngest, ports low to high: the last match assigned
    // is the youngest entry, highest port within it.
    always_comb begin
        fwd_data_o = '0;
        for (int p = 0; p < NPORT; p++)
            for (int k = HZW - 1; k >= 0; k--)
                for (int q = 0; q < NPORT; q++)
                    if (ent_q[k][q].en && ent_q[k][q].addr == rd_addr_i[p])
                        fwd_data_o[p] = ent_q[k][q].data;
    end
`endif
endmodule

// File: rtl/memblk_pq.sv
// memblk_pq: NPORT read + NPORT write ports into one DEPTH-word array with
// per-word metadata {xdata, shared}. Requests flow through LAT stages; stage
// A=LAT-1 accesses the array; writes are posted via memblk_pq_wbuf.
// Optional macro MEMBLK_PQ_FWD_EN: reads hitting posted writes forward data
// instead of stalling (stall tied low).
//   clk, rst            clock, async active-low reset
//   stall               upstream holds all request inputs while high
//   noshare             reads at A clear shared instead of setting it
//   rd_en/addr/xdata    read requests (xdata is written into metadata)
//   rd_valid/data/meta  read responses; meta is the pre-update value
//   wr_en/addr/data     write requests
module memblk_pq
    import memblk_pq_pkg::*;
#(
    parameter int NPORT = PQ_NPORT,
    parameter int AW    = PQ_AW,
    parameter int DW    = PQ_DW,
    parameter int XW    = PQ_XW,
    parameter int LAT   = PQ_LAT,
    parameter int HZW   = PQ_HZW
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      stall,
    input  logic                      noshare,
    input  logic [NPORT-1:0]          rd_en,
    input  logic [NPORT-1:0][AW-1:0]  rd_addr,
    input  logic [NPORT-1:0][XW-1:0]  rd_xdata,
    output logic [NPORT-1:0]          rd_valid,
    output logic [NPORT-1:0][DW-1:0]  rd_data,
    output logic [NPORT-1:0][XW:0]    rd_meta,
    input  logic [NPORT-1:0]          wr_en,
    input  logic [NPORT-1:0][AW-1:0]  wr_addr,
    input  logic [NPORT-1:0][DW-1:0]  wr_data
);
    localparam int DEPTH = 1 << AW;

    rd_req_t [NPORT-1:0] rd_pipe_q [LAT];
    wr_req_t [NPORT-1:0] wr_pipe_q [LAT];
    logic    [LAT-1:0]   vld_pipe_q;
    rd_req_t [NPORT-1:0] rd_in, rd_a;
    wr_req_t [NPORT-1:0] wr_in, wr_a, cmt;
    logic    [NPORT-1:0] rd_a_en, hit;
    logic    [NPORT-1:0][AW-1:0] rd_a_addr;

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            rd_in[p]     = '{en: rd_en[p], addr: rd_addr[p], xdata: rd_xdata[p]};
            wr_in[p]     = '{en: wr_en[p], addr: wr_addr[p], data: wr_data[p]};
            rd_a[p]      = rd_pipe_q[A][p];
            wr_a[p]      = wr_pipe_q[A][p];
            rd_a_en[p]   = vld_pipe_q[A] & rd_a[p].en;
            wr_a[p].en   = vld_pipe_q[A] & wr_pipe_q[A][p].en;
            rd_a_addr[p] = rd_a[p].addr;
        end
    end

    // Request pipeline: the whole thing freezes on stall, so the held
    // upstream inputs are taken exactly once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                rd_pipe_q[k] <= '0;
                wr_pipe_q[k] <= '0;
            end
        end else if (!stall) begin
            vld_pipe_q   <= {vld_pipe_q[LAT-2:0], (|rd_en) | (|wr_en)};
            rd_pipe_q[0] <= rd_in;
            wr_pipe_q[0] <= wr_in;
            for (int k = 1; k < LAT; k++) begin
                rd_pipe_q[k] <= rd_pipe_q[k-1];
                wr_pipe_q[k] <= wr_pipe_q[k-1];
            end
        end
    end

`ifdef MEMBLK_PQ_FWD_EN
    logic [NPORT-1:0][DW-1:0] fwd_data;
`endif

    memblk_pq_wbuf #(.NPORT(NPORT), .HZW(HZW)) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .push_i    (~stall),
        .wr_i      (wr_a),
        .rd_addr_i (rd_a_addr),
        .hit_o     (hit),
        .cmt_o     (cmt)
`ifdef MEMBLK_PQ_FWD_EN
        ,
        .fwd_data_o(fwd_data)
`endif
    );

`ifdef MEMBLK_PQ_FWD_EN
    assign stall = 1'b0;
`else
    assign stall = |(rd_a_en & hit);
`endif

    // Data array is not reset. Metadata reset is done through a per-word
    // valid vector: a word whose bit is clear reads as all-zero metadata.
    logic [DW-1:0]    mem_q  [DEPTH];
    meta_t            meta_q [DEPTH];
    logic [DEPTH-1:0] mvld_q;
    meta_t [NPORT-1:0] cmt_meta, rd_meta_d;
    logic  [NPORT-1:0][DW-1:0] rd_data_d;

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            cmt_meta[p].xdata  = mvld_q[cmt[p].addr] ? meta_q[cmt[p].addr].xdata : '0;
            cmt_meta[p].shared = 1'b0;
            rd_meta_d[p]       = mvld_q[rd_a[p].addr] ? meta_q[rd_a[p].addr] : '0;
            rd_data_d[p]       = mem_q[rd_a[p].addr];
`ifdef MEMBLK_PQ_FWD_EN
            if (hit[p]) rd_data_d[p] = fwd_data[p];
`endif
        end
    end

    // Port loops run low to high so the highest port wins on address ties.
    always_ff @(posedge clk) begin
        for (int q = 0; q < NPORT; q++)
            if (cmt[q].en) mem_q[cmt[q].addr] <= cmt[q].data;
    end

    // A read update at A lands after a same-word commit clear (only reachable
    // with forwarding, since otherwise such a read is stalled).
    always_ff @(posedge clk) begin
        for (int q = 0; q < NPORT; q++)
            if (cmt[q].en) meta_q[cmt[q].addr] <= cmt_meta[q];
        if (!stall)
            for (int p = 0; p < NPORT; p++)
                if (rd_a_en[p]) meta_q[rd_a[p].addr] <= '{xdata: rd_a[p].xdata, shared: ~noshare};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mvld_q <= '0;
        end else begin
            for (int q = 0; q < NPORT; q++)
                if (cmt[q].en) mvld_q[cmt[q].addr] <= 1'b1;
            if (!stall)
                for (int p = 0; p < NPORT; p++)
                    if (rd_a_en[p]) mvld_q[rd_a[p].addr] <= 1'b1;
        end
    end

    logic  [NPORT-1:0]         rd_valid_q;
    logic  [NPORT-1:0][DW-1:0] rd_data_q;
    meta_t [NPORT-1:0]         rd_meta_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            rd_meta_q  <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                rd_valid_q[p] <= rd_a_en[p] & ~stall;
                if (rd_a_en[p] && !stall) begin
                    rd_data_q[p] <= rd_data_d[p];
                    rd_meta_q[p] <= rd_meta_d[p];
                end
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_meta  = rd_meta_q;
endmodule

// File: tb/tb_memblk_pq.sv
module tb_memblk_pq;
    localparam int NP = 4, AW = 16, DW = 64, XW = 4, LAT = 4, HZW = 4;

    logic clk = 1'b0, rst = 1'b0, stall, noshare = 1'b0;
    logic [NP-1:0]         rd_en = '0, wr_en = '0, rd_valid;
    logic [NP-1:0][AW-1:0] rd_addr = '0, wr_addr = '0;
    logic [NP-1:0][XW-1:0] rd_xdata = '0;
    logic [NP-1:0][DW-1:0] rd_data, wr_data = '0;
    logic [NP-1:0][XW:0]   rd_meta;

    memblk_pq #(.NPORT(NP), .AW(AW), .DW(DW), .XW(XW), .LAT(LAT), .HZW(HZW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .noshare(noshare),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_xdata(rd_xdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_meta(rd_meta),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        bit            dknown;
        logic [XW:0]   meta;
    } exp_t;

    exp_t          expq [NP][$];
    logic [DW-1:0] mdl_data [int];
    logic [XW:0]   mdl_meta [int];
    int checks = 0, errors = 0, cyc = 0, stall_cnt = 0, vld_cnt = 0, consec = 0, acc_cyc = 0;
    int            last_cyc  [NP];
    logic [DW-1:0] last_data [NP];
    logic [XW:0]   last_meta [NP];
    int pool [8] = '{32'h0010, 32'h0020, 32'h0030, 32'h0042, 32'h0055, 32'h1234, 32'hBEEF, 32'hFFFF};

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [XW:0] meta_of(input int a);
        return mdl_meta.exists(a) ? mdl_meta[a] : '0;
    endfunction

    // Reference: the memory behaves as if every accepted request cycle were
    // applied atomically in acceptance order: reads see the state before the
    // cycle, then read metadata updates, then writes (which clear shared).
    task automatic accept();
        exp_t e;
        logic [XW:0] m;
        for (int p = 0; p < NP; p++)
            if (rd_en[p]) begin
                int a = int'(rd_addr[p]);
                e.dknown = mdl_data.exists(a);
                e.data   = e.dknown ? mdl_data[a] : '0;
                e.meta   = meta_of(a);
                expq[p].push_back(e);
            end
        for (int p = 0; p < NP; p++)
            if (rd_en[p]) mdl_meta[int'(rd_addr[p])] = {rd_xdata[p], ~noshare};
        for (int p = 0; p < NP; p++)
            if (wr_en[p]) begin
                int a = int'(wr_addr[p]);
                mdl_data[a] = wr_data[p];
                m = meta_of(a);
                m[0] = 1'b0;
                mdl_meta[a] = m;
            end
    endtask

    // Monitor: pops and compares whenever a response is presented.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            if (stall) begin
                stall_cnt++;
                consec++;
                checks++;
                if (consec > HZW) begin
                    errors++;
                    $display("FAIL stall_bound: got %0d consecutive stall cycles, limit %0d", consec, HZW);
                end
            end else consec = 0;
            for (int p = 0; p < NP; p++)
                if (rd_valid[p]) begin
                    vld_cnt++;
                    last_cyc[p]  = cyc;
                    last_data[p] = rd_data[p];
                    last_meta[p] = rd_meta[p];
                    checks++;
                    if (expq[p].size() == 0) begin
                        errors++;
                        $display("FAIL spurious_rd_valid port %0d: got valid, expected none", p);
                    end else begin
                        e = expq[p].pop_front();
                        if (e.dknown && rd_data[p] !== e.data) begin
                            errors++;
                            $display("FAIL rd_data port %0d: got %0h, expected %0h", p, rd_data[p], e.data);
                        end
`ifndef MEMBLK_PQ_FWD_EN
                        if (rd_meta[p] !== e.meta) begin
                            errors++;
                            $display("FAIL rd_meta port %0d: got %0h, expected %0h", p, rd_meta[p], e.meta);
                        end
`endif
                    end
                end
        end
    end

    task automatic clr();
        rd_en = '0;
        wr_en = '0;
    endtask

    // Present the current inputs until accepted (stall low at the sample).
    task automatic step();
        int g = 0;
        forever begin
            @(negedge clk);
            if (!stall) begin
                acc_cyc = cyc;
                accept();
                break;
            end
            g++;
            if (g > 50) begin
                errors++;
                $display("FAIL accept_timeout: got stall for %0d cycles, expected release", g);
                break;
            end
        end
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic do_wr(input int p, input int a, input logic [DW-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p] = AW'(a);
        wr_data[p] = d;
    endtask

    task automatic do_rd(input int p, input int a, input logic [XW-1:0] x);
        rd_en[p] = 1'b1;
        rd_addr[p] = AW'(a);
        rd_xdata[p] = x;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        int n = 0;
        while ((expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout: got %0d responses outstanding, expected 0",
                     expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size());
        end
        repeat (LAT + HZW + 2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        for (int i = 0; i < 8; i++) begin
            do_wr(i % NP, pool[i], 64'h5555_0000_0000_0000 | 64'(pool[i]));
            step();
        end
        drain();
    endtask

    task automatic rand_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            for (int p = 0; p < NP; p++) begin
                rd_en[p]    = ($urandom_range(0, 99) < 40);
                rd_addr[p]  = AW'(pool[$urandom_range(0, 7)]);
                rd_xdata[p] = XW'($urandom);
                wr_en[p]    = ($urandom_range(0, 99) < 25);
                wr_addr[p]  = AW'(pool[$urandom_range(0, 7)]);
                wr_data[p]  = {$urandom, $urandom};
            end
            step();
        end
    endtask

    initial begin
        int t0, s0, v0;
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, s0, v0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_rd_valid", 64'(rd_valid), 64'h0);
        chk("reset_stall", 64'(stall), 64'h0);
        @(posedge clk);
        #1;
        preload();

        // Write, then read after commit.
        do_wr(0, 32'h0010, 64'hDEADBEEF);
        step();
        s0 = stall_cnt;
        idle(7);
        do_rd(1, 32'h0010, 4'h0);
        step();
        t0 = acc_cyc;
        drain();
        chk("after_commit_latency", 64'(last_cyc[1] - t0), 64'(LAT + 1));
        chk("after_commit_data", last_data[1], 64'hDEADBEEF);
        chk("after_commit_no_stall", 64'(stall_cnt - s0), 64'h0);

        // Write then read back-to-back.
        do_wr(0, 32'h0010, 64'h0);
        step();
        drain();
        s0 = stall_cnt;
        do_wr(0, 32'h0010, 64'hDEADBEEF);
        step();
        do_rd(1, 32'h0010, 4'h0);
        step();
        t0 = acc_cyc;
        drain();
        chk("b2b_data", last_data[1], 64'hDEADBEEF);
`ifdef MEMBLK_PQ_FWD_EN
        chk("b2b_stall_cycles", 64'(stall_cnt - s0), 64'h0);
        chk("b2b_latency", 64'(last_cyc[1] - t0), 64'(LAT + 1));
`else
        chk("b2b_stall_cycles", 64'(stall_cnt - s0), 64'(HZW));
        chk("b2b_latency", 64'(last_cyc[1] - t0), 64'(LAT + 1 + HZW));
`endif

        // Same-cycle write collision.
        do_wr(1, 32'h0020, 64'h1111);
        do_wr(3, 32'h0020, 64'h3333);
        step();
        idle(2);
        drain();
        do_rd(2, 32'h0020, 4'h0);
        step();
        drain();
        chk("collision_data", last_data[2], 64'h3333);

        // Metadata sequence on 0x0030.
        do_rd(0, 32'h0030, 4'hA);
        step();
        do_rd(0, 32'h0030, 4'hA);
        step();
        drain();
        chk("meta_after_read", 64'(last_meta[0]), 64'h15);
        do_wr(2, 32'h0030, 64'h0303);
        step();
        drain();
        do_rd(0, 32'h0030, 4'hA);
        step();
        drain();
        chk("meta_after_commit", 64'(last_meta[0]), 64'h14);
        noshare = 1'b1;
        do_rd(3, 32'h0030, 4'hA);
        step();
        drain();
        chk("meta_before_noshare", 64'(last_meta[3]), 64'h15);
        do_rd(3, 32'h0030, 4'hA);
        step();
        drain();
        chk("meta_after_noshare", 64'(last_meta[3]), 64'h14);
        noshare = 1'b0;

        // Upstream hold across a forced stall.
        s0 = stall_cnt;
        v0 = vld_cnt;
        do_wr(3, 32'h0055, 64'h5A5A);
        step();
        for (int i = 0; i < 8; i++) begin
            do_rd(0, (i == 0) ? 32'h0055 : pool[$urandom_range(0, 7)], XW'($urandom));
            step();
        end
        drain();
        chk("hold_rd_valid_pulses", 64'(vld_cnt - v0), 64'd8);
`ifndef MEMBLK_PQ_FWD_EN
        chk("hold_stall_cycles", 64'(stall_cnt - s0), 64'(HZW));
`endif

        // Randomised traffic, both noshare settings.
        rand_traffic(250);
        drain();
        noshare = 1'b1;
        rand_traffic(150);
        drain();
        noshare = 1'b0;

        // Reset in the middle of traffic.
        rand_traffic(12);
        for (int p = 0; p < NP; p++) rd_en[p] = 1'b1;
        rst = 1'b0;
        for (int p = 0; p < NP; p++) expq[p].delete();
        mdl_data.delete();
        mdl_meta.delete();
        @(negedge clk);
        chk("midreset_rd_valid", 64'(rd_valid), 64'h0);
        chk("midreset_stall", 64'(stall), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        clr();
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_rd_valid", 64'(rd_valid), 64'h0);
        @(posedge clk);
        #1;
        do_rd(2, 32'h0042, 4'h7);
        step();
        drain();
        chk("post_reset_meta", 64'(last_meta[2]), 64'h0);
        preload();
        rand_traffic(100);
        drain();

        for (int p = 0; p < NP; p++) chk("queue_empty", 64'(expq[p].size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
